// File: rtl/lin_pkg.sv
// ----------------------------------------------------------------------------
// lin_pkg
// Shared definitions for the LIN slave controller:
//   - FSM state encoding (plain localparams so legacy code can reuse them)
//   - reserved diagnostic frame IDs
//   - PID parity and response-length-by-ID helpers
// ----------------------------------------------------------------------------
package lin_pkg;

  localparam logic [2:0] ST_INIT    = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_RX_DATA = 3'd2;
  localparam logic [2:0] ST_RX_CHK  = 3'd3;
  localparam logic [2:0] ST_TX_RESP = 3'd4;
  localparam logic [2:0] ST_SLEEP   = 3'd5;
  localparam logic [2:0] ST_WAKE    = 3'd6;

  localparam logic [5:0] ID_MASTER_REQ = 6'h3C;
  localparam logic [5:0] ID_SLAVE_RESP = 6'h3D;

  // Returns {P1, P0}, i.e. the value expected in pid[7:6].
  function automatic logic [1:0] lin_parity(input logic [5:0] id);
    lin_parity = {~(id[1] ^ id[3] ^ id[4] ^ id[5]),
                    id[0] ^ id[1] ^ id[2] ^ id[4]};
  endfunction

  function automatic logic [3:0] len_for_id(input logic [5:0] id);
    if (id == ID_MASTER_REQ)  len_for_id = 4'd8;
    else if (id < 6'd32)      len_for_id = 4'd2;
    else if (id < 6'd48)      len_for_id = 4'd4;
    else                      len_for_id = 4'd8;
  endfunction

  // Diagnostic frames use the classic checksum (PID not included).
  function automatic logic is_classic_id(input logic [5:0] id);
    is_classic_id = (id == ID_MASTER_REQ) || (id == ID_SLAVE_RESP);
  endfunction

endpackage

// File: rtl/lin_slave_controller_if.sv
// ----------------------------------------------------------------------------
// lin_slave_controller_if
// Frame-level bus between the LIN byte receiver / response transmitter and
// the slave controller.
//   slave  modport : the controller (consumes headers/bytes, emits responses)
//   master modport : the receiver/transmitter side driving the controller
// ----------------------------------------------------------------------------
interface lin_slave_controller_if;
  logic       header_valid;  // pulse: PID byte received after break/sync
  logic [7:0] pid;           // protected identifier, valid with header_valid
  logic       rx_byte_valid; // pulse: data/checksum byte received
  logic [7:0] rx_byte;       // received byte
  logic       tx_done;       // pulse: transmitter finished the response
  logic       tx_start;      // pulse: start transmitting response for resp_id
  logic [5:0] resp_id;       // frame ID being handled
  logic [3:0] resp_len;      // data bytes in the response (2, 4 or 8)
  logic       rx_active;     // high while collecting a subscribed response
  logic       frame_ok;      // pulse: frame completed correctly
  logic       frame_err;     // pulse: parity, checksum, timeout or abort

  modport slave (
    input  header_valid, pid, rx_byte_valid, rx_byte, tx_done,
    output tx_start, resp_id, resp_len, rx_active, frame_ok, frame_err
  );

  modport master (
    output header_valid, pid, rx_byte_valid, rx_byte, tx_done,
    input  tx_start, resp_id, resp_len, rx_active, frame_ok, frame_err
  );
endinterface

// File: rtl/lin_checksum_acc.sv
// ----------------------------------------------------------------------------
// lin_checksum_acc
// Running LIN checksum: 8-bit sum with end-around carry, output inverted.
//   clk, reset : clock, asynchronous active-low reset
//   clear      : load the accumulator with seed (PID or 0)
//   seed       : initial sum value
//   enable     : add data into the running sum
//   data       : byte to accumulate
//   chk        : inverted sum, i.e. the checksum byte expected on the bus
// ----------------------------------------------------------------------------
module lin_checksum_acc (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic [7:0] seed,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] chk
);

  logic [7:0] sum_q;
  logic [8:0] raw_sum;

  assign raw_sum = {1'b0, sum_q} + {1'b0, data};

  // Folding the carry back in cannot overflow again (max 0xFE + 1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q <= 8'h00;
    end else if (clear) begin
      sum_q <= seed;
    end else if (enable) begin
      sum_q <= raw_sum[7:0] + {7'b0, raw_sum[8]};
    end
  end

  assign chk = ~sum_q;

endmodule

// File: rtl/lin_slave_controller.sv
// ----------------------------------------------------------------------------
// lin_slave_controller
// Protocol state machine for a LIN slave node: decides per PID whether to
// publish, subscribe or ignore, checks response checksums, and handles
// init, go-to-sleep, bus-inactivity sleep and wakeup.
//   clk, reset   : clock, asynchronous active-low reset
//   bit_tick     : one-cycle pulse per LIN bit time
//   bus_dominant : synchronized RX level, 1 = dominant
//   local_wake   : application wake request (level)
//   bus          : frame-level handshake (lin_slave_controller_if.slave)
//   sleep_mode   : high in SLEEP
//   wake_drive   : high while driving the wakeup pulse
//   init_finish  : high once INIT has completed (cleared only by reset)
// ----------------------------------------------------------------------------
module lin_slave_controller
  import lin_pkg::*;
#(
  parameter int          INIT_TICKS   = 30,
  parameter int          IDLE_TIMEOUT = 76800,
  parameter int          RESP_TIMEOUT = 140,
  parameter int          WAKE_TICKS   = 8,
  parameter logic [63:0] PUB_MASK     = 64'h0,
  parameter logic [63:0] SUB_MASK     = 64'h0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bit_tick,
  input  logic                         bus_dominant,
  input  logic                         local_wake,
  lin_slave_controller_if.slave        bus,
  output logic                         sleep_mode,
  output logic                         wake_drive,
  output logic                         init_finish
);

  localparam int MAX_A    = (INIT_TICKS > IDLE_TIMEOUT) ? INIT_TICKS : IDLE_TIMEOUT;
  localparam int MAX_B    = (RESP_TIMEOUT > WAKE_TICKS) ? RESP_TIMEOUT : WAKE_TICKS;
  localparam int MAX_T    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W    = $clog2(MAX_T + 1);

  // A limit is "reached" on the tick that would make the count equal it.
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TICKS - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] RESP_LAST = CNT_W'(RESP_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] tick_cnt, cnt_n;
  logic [3:0]       byte_idx;
  logic [7:0]       mreq_b0;        // byte 0 of the last master request

  logic             tx_start_q, frame_ok_q, frame_err_q, rx_active_q;
  logic [5:0]       resp_id_q;
  logic [3:0]       resp_len_q;

  logic             tx_start_n, frame_ok_n, frame_err_n;
  logic             hdr_eval, hdr_take, acc_clear, acc_en, resp_to;
  logic [5:0]       hdr_id;
  logic [7:0]       acc_seed, acc_chk;

  assign hdr_id   = bus.pid[5:0];
  assign acc_seed = is_classic_id(hdr_id) ? 8'h00 : bus.pid;
  assign resp_to  = bit_tick && (tick_cnt == RESP_LAST);

  lin_checksum_acc u_chk (
    .clk    (clk),
    .reset  (reset),
    .clear  (acc_clear),
    .seed   (acc_seed),
    .enable (acc_en),
    .data   (bus.rx_byte),
    .chk    (acc_chk)
  );

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n     = state;
    tx_start_n  = 1'b0;
    frame_ok_n  = 1'b0;
    frame_err_n = 1'b0;
    acc_clear   = 1'b0;
    acc_en      = 1'b0;
    hdr_take    = 1'b0;
    hdr_eval    = bus.header_valid &&
                  (state inside {ST_IDLE, ST_RX_DATA, ST_RX_CHK, ST_TX_RESP});

    case (state)
      ST_INIT: begin
        if (bit_tick && tick_cnt == INIT_LAST) state_n = ST_IDLE;
      end
      ST_IDLE: begin
        if (bit_tick && !bus_dominant && tick_cnt == IDLE_LAST) state_n = ST_SLEEP;
      end
      ST_RX_DATA: begin
        if (bus.rx_byte_valid) begin
          acc_en = 1'b1;
          if (byte_idx == resp_len_q - 4'd1) state_n = ST_RX_CHK;
        end else if (resp_to) begin
          frame_err_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      ST_RX_CHK: begin
        if (bus.rx_byte_valid) begin
          state_n = ST_IDLE;
          if (bus.rx_byte == acc_chk) begin
            frame_ok_n = 1'b1;
            if (resp_id_q == ID_MASTER_REQ && mreq_b0 == 8'h00) state_n = ST_SLEEP;
          end else begin
            frame_err_n = 1'b1;
          end
        end else if (resp_to) begin
          frame_err_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      ST_TX_RESP: begin
        if (bus.tx_done) begin
          frame_ok_n = 1'b1;
          state_n    = ST_IDLE;
        end else if (resp_to) begin
          frame_err_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      ST_SLEEP: begin
        // Bus wakeup has priority over a local request in the same cycle.
        if (bit_tick && bus_dominant) state_n = ST_INIT;
        else if (local_wake)          state_n = ST_WAKE;
      end
      ST_WAKE: begin
        if (bit_tick && tick_cnt == WAKE_LAST) state_n = ST_INIT;
      end
      default: state_n = ST_INIT;
    endcase

    // A header overrides whatever the current frame was doing: the old frame
    // is aborted and the new PID is decoded in this same cycle.
    if (hdr_eval) begin
      state_n     = ST_IDLE;
      acc_en      = 1'b0;
      frame_ok_n  = 1'b0;
      frame_err_n = (state != ST_IDLE);
      if (bus.pid[7:6] != lin_parity(hdr_id)) begin
        frame_err_n = 1'b1;
      end else begin
        hdr_take = 1'b1;
        if (PUB_MASK[hdr_id]) begin
          tx_start_n = 1'b1;
          state_n    = ST_TX_RESP;
        end else if (SUB_MASK[hdr_id] || hdr_id == ID_MASTER_REQ) begin
          acc_clear = 1'b1;
          state_n   = ST_RX_DATA;
        end
      end
    end

    // A newly accepted frame restarts the phase timer even if the state code
    // happens not to change (e.g. subscribe aborted by another subscribe).
    if (state_n != state || hdr_take)            cnt_n = '0;
    else if (state == ST_IDLE && bus_dominant)   cnt_n = '0;
    else if (bit_tick)                           cnt_n = tick_cnt + CNT_ONE;
    else                                         cnt_n = tick_cnt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_INIT;
      tick_cnt    <= '0;
      byte_idx    <= 4'd0;
      mreq_b0     <= 8'h00;
      tx_start_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_active_q <= 1'b0;
      resp_id_q   <= 6'h00;
      resp_len_q  <= 4'd2;
      sleep_mode  <= 1'b0;
      wake_drive  <= 1'b0;
      init_finish <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= cnt_n;
      tx_start_q  <= tx_start_n;
      frame_ok_q  <= frame_ok_n;
      frame_err_q <= frame_err_n;
      rx_active_q <= (state_n == ST_RX_DATA) || (state_n == ST_RX_CHK);
      sleep_mode  <= (state_n == ST_SLEEP);
      wake_drive  <= (state_n == ST_WAKE);
      if (state == ST_INIT && state_n == ST_IDLE) init_finish <= 1'b1;

      if (hdr_take) begin
        resp_id_q  <= hdr_id;
        resp_len_q <= len_for_id(hdr_id);
        byte_idx   <= 4'd0;
      end else if (acc_en) begin
        byte_idx <= byte_idx + 4'd1;
      end
      if (acc_en && byte_idx == 4'd0) mreq_b0 <= bus.rx_byte;
    end
  end

  assign bus.tx_start  = tx_start_q;
  assign bus.frame_ok  = frame_ok_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_active = rx_active_q;
  assign bus.resp_id   = resp_id_q;
  assign bus.resp_len  = resp_len_q;

endmodule

// File: tb/tb_lin_slave_controller.sv
// ----------------------------------------------------------------------------
// tb_lin_slave_controller
// Directed bench: a table of header vectors with hand-computed responses,
// followed by hand-written multi-cycle sequences (publish, subscribe with
// good/bad checksum, timeout, abort, go-to-sleep, wakeups, idle timeout,
// mid-frame reset). bit_tick, when asserted, is high for whole clock cycles.
// ----------------------------------------------------------------------------
module tb_lin_slave_controller;

  // Shortened so the inactivity path runs in a few thousand cycles.
  localparam int          IDLE_TO  = 1200;
  localparam logic [63:0] PUB      = (64'h1 << 6'h10) | (64'h1 << 6'h30);
  // ID 0x10 is in both masks: publishing must win.
  localparam logic [63:0] SUB      = (64'h1 << 6'h22) | (64'h1 << 6'h05) | (64'h1 << 6'h10);

  logic clk = 1'b0;
  logic reset;
  logic bit_tick, bus_dominant, local_wake;
  logic sleep_mode, wake_drive, init_finish;

  int n_cmp = 0;
  int n_bad = 0;

  lin_slave_controller_if bus ();

  lin_slave_controller #(
    .INIT_TICKS   (30),
    .IDLE_TIMEOUT (IDLE_TO),
    .RESP_TIMEOUT (140),
    .WAKE_TICKS   (8),
    .PUB_MASK     (PUB),
    .SUB_MASK     (SUB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bit_tick     (bit_tick),
    .bus_dominant (bus_dominant),
    .local_wake   (local_wake),
    .bus          (bus),
    .sleep_mode   (sleep_mode),
    .wake_drive   (wake_drive),
    .init_finish  (init_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pid;
    logic       exp_err;
    logic       exp_tx;
    logic       exp_rx;
    logic [3:0] exp_len;
    logic [5:0] exp_id;
  } hdr_vec_t;

  hdr_vec_t vec [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    bit_tick = 1'b1;
    repeat (n) step();
    bit_tick = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] p);
    bus.pid          = p;
    bus.header_valid = 1'b1;
    step();
    bus.header_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_byte       = b;
    bus.rx_byte_valid = 1'b1;
    step();
    bus.rx_byte_valid = 1'b0;
  endtask

  task automatic send_tx_done();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  initial begin
    // pid, err, tx_start, rx_active, resp_len, resp_id
    vec[0] = '{8'h50, 1'b0, 1'b1, 1'b0, 4'd2, 6'h10}; // publish (wins over sub)
    vec[1] = '{8'hE2, 1'b0, 1'b0, 1'b1, 4'd4, 6'h22}; // subscribe, 4 bytes
    vec[2] = '{8'hA8, 1'b0, 1'b0, 1'b0, 4'd4, 6'h28}; // ignored, 4 bytes
    vec[3] = '{8'h28, 1'b1, 1'b0, 1'b0, 4'd4, 6'h28}; // bad parity, len/id held
    vec[4] = '{8'h3C, 1'b0, 1'b0, 1'b1, 4'd8, 6'h3C}; // master request always sub
    vec[5] = '{8'hF0, 1'b0, 1'b1, 1'b0, 4'd8, 6'h30}; // publish, 8 bytes
    vec[6] = '{8'h85, 1'b0, 1'b0, 1'b1, 4'd2, 6'h05}; // subscribe, 2 bytes
    vec[7] = '{8'hC1, 1'b0, 1'b0, 1'b0, 4'd2, 6'h01}; // ignored
    vec[8] = '{8'h7D, 1'b0, 1'b0, 1'b0, 4'd8, 6'h3D}; // slave response, ignored
    vec[9] = '{8'h10, 1'b1, 1'b0, 1'b0, 4'd8, 6'h3D}; // bad parity

    reset             = 1'b0;
    bit_tick          = 1'b0;
    bus_dominant      = 1'b0;
    local_wake        = 1'b0;
    bus.header_valid  = 1'b0;
    bus.pid           = 8'h00;
    bus.rx_byte_valid = 1'b0;
    bus.rx_byte       = 8'h00;
    bus.tx_done       = 1'b0;

    // ---- reset state ----
    repeat (3) step();
    check("rst.tx_start",  bus.tx_start,  0);
    check("rst.resp_len",  bus.resp_len,  2);
    check("rst.resp_id",   bus.resp_id,   0);
    check("rst.rx_active", bus.rx_active, 0);
    check("rst.frame_ok",  bus.frame_ok,  0);
    check("rst.frame_err", bus.frame_err, 0);
    check("rst.sleep",     sleep_mode,    0);
    check("rst.wake",      wake_drive,    0);
    check("rst.init_fin",  init_finish,   0);
    reset = 1'b1;
    step();

    // ---- INIT: init_finish rises on tick 30 ----
    ticks(29);
    check("init.tick29", init_finish, 0);
    ticks(1);
    check("init.tick30", init_finish, 1);
    check("init.sleep",  sleep_mode,  0);

    // ---- header decode table ----
    for (int i = 0; i < 10; i++) begin
      send_hdr(vec[i].pid);
      check($sformatf("vec%0d.frame_err", i), bus.frame_err, vec[i].exp_err);
      check($sformatf("vec%0d.tx_start", i),  bus.tx_start,  vec[i].exp_tx);
      check($sformatf("vec%0d.rx_active", i), bus.rx_active, vec[i].exp_rx);
      check($sformatf("vec%0d.resp_len", i),  bus.resp_len,  vec[i].exp_len);
      check($sformatf("vec%0d.resp_id", i),   bus.resp_id,   vec[i].exp_id);
      if (vec[i].exp_tx) send_tx_done();
      if (vec[i].exp_rx) send_hdr(8'hC1); // abort via an ignored header
    end

    // ---- publish: one-cycle tx_start, frame_ok on tx_done ----
    send_hdr(8'h50);
    check("pub.tx_start", bus.tx_start, 1);
    step();
    check("pub.tx_start_w", bus.tx_start, 0);
    send_tx_done();
    check("pub.frame_ok", bus.frame_ok, 1);
    step();
    check("pub.frame_ok_w", bus.frame_ok, 0);

    // ---- subscribe 0x22, enhanced checksum 0x72 ----
    send_hdr(8'hE2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check("sub.rx_active", bus.rx_active, 1);
    send_byte(8'h72);
    check("sub.frame_ok",  bus.frame_ok,  1);
    check("sub.frame_err", bus.frame_err, 0);
    check("sub.rx_drop",   bus.rx_active, 0);
    send_hdr(8'hE2);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h73);
    check("subbad.frame_ok",  bus.frame_ok,  0);
    check("subbad.frame_err", bus.frame_err, 1);
    check("subbad.rx_drop",   bus.rx_active, 0);

    // ---- response timeout: 2 bytes then 140 silent ticks ----
    send_hdr(8'hE2);
    send_byte(8'h11); send_byte(8'h22);
    ticks(139);
    check("to.tick139.err", bus.frame_err, 0);
    check("to.tick139.rx",  bus.rx_active, 1);
    ticks(1);
    check("to.tick140.err", bus.frame_err, 1);
    check("to.tick140.rx",  bus.rx_active, 0);

    // ---- new header mid-response: abort and decode in one cycle ----
    send_hdr(8'hE2);
    send_byte(8'h11);
    send_hdr(8'h50);
    check("abort.frame_err", bus.frame_err, 1);
    check("abort.tx_start",  bus.tx_start,  1);
    check("abort.rx_drop",   bus.rx_active, 0);
    send_tx_done();
    check("abort.frame_ok",  bus.frame_ok,  1);

    // ---- go-to-sleep: 0x3C, byte0 = 0x00, classic checksum 0x00 ----
    send_hdr(8'h3C);
    send_byte(8'h00);
    repeat (7) send_byte(8'hFF);
    send_byte(8'h00);
    check("gts.frame_ok", bus.frame_ok, 1);
    step();
    check("gts.sleep", sleep_mode, 1);

    // ---- local wake: 8 ticks of wake_drive, then INIT for 30 ticks ----
    local_wake = 1'b1;
    step();
    local_wake = 1'b0;
    check("lw.wake_drive", wake_drive, 1);
    check("lw.sleep_off",  sleep_mode, 0);
    ticks(7);
    check("lw.tick7", wake_drive, 1);
    ticks(1);
    check("lw.tick8",     wake_drive,  0);
    check("lw.init_kept", init_finish, 1);
    ticks(29);
    send_hdr(8'h50);
    check("lw.init_ignores", bus.tx_start, 0);
    ticks(1);
    send_hdr(8'h50);
    check("lw.idle_again", bus.tx_start, 1);
    send_tx_done();

    // ---- bus inactivity; a dominant level restarts the count ----
    ticks(IDLE_TO - 5);
    bus_dominant = 1'b1;
    step();
    bus_dominant = 1'b0;
    ticks(IDLE_TO - 1);
    check("idle.before", sleep_mode, 0);
    ticks(1);
    check("idle.sleep", sleep_mode, 1);

    // ---- bus wakeup needs a tick; dominant alone does nothing ----
    bus_dominant = 1'b1;
    step();
    check("bw.no_tick", sleep_mode, 1);
    bit_tick = 1'b1;
    step();
    bit_tick     = 1'b0;
    bus_dominant = 1'b0;
    check("bw.sleep_off", sleep_mode, 0);
    check("bw.no_wake",   wake_drive, 0);

    // ---- bus wakeup wins over local wake in the same cycle ----
    ticks(30);
    ticks(IDLE_TO);
    check("both.asleep", sleep_mode, 1);
    local_wake   = 1'b1;
    bus_dominant = 1'b1;
    bit_tick     = 1'b1;
    step();
    local_wake   = 1'b0;
    bus_dominant = 1'b0;
    bit_tick     = 1'b0;
    check("both.sleep_off", sleep_mode, 0);
    check("both.no_wake",   wake_drive, 0);

    // ---- reset mid-frame: back to reset values, no pulse ----
    ticks(30);
    send_hdr(8'hE2);
    send_byte(8'h11);
    reset = 1'b0;
    #2;
    check("mrst.frame_err", bus.frame_err, 0);
    check("mrst.frame_ok",  bus.frame_ok,  0);
    check("mrst.rx_active", bus.rx_active, 0);
    check("mrst.resp_len",  bus.resp_len,  2);
    check("mrst.init_fin",  init_finish,   0);
    step();
    reset = 1'b1;
    step();
    check("mrst.after_err", bus.frame_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lin_slave_controller.md
Name: lin_slave_controller

Overview:
- Protocol-level state machine for a LIN slave node. It is the responder counterpart to the cluster master controller.
- Consumes decoded headers and received bytes from the LIN byte receiver, and decides per protected identifier (PID) whether to publish, subscribe or ignore.
- Verifies response checksums and manages init, go-to-sleep, bus-inactivity sleep and wakeup.
- Sits between the LIN UART/break detector and the node's response buffer/transmitter.

Parameters:
- INIT_TICKS, 30, bit ticks spent in INIT before operation.
- IDLE_TIMEOUT, 76800, bit ticks of recessive bus that force SLEEP (4 s at 19200 bd).
- RESP_TIMEOUT, 140, bit ticks allowed per response phase before abort.
- WAKE_TICKS, 8, bit ticks the wakeup pulse is driven dominant.
- PUB_MASK, 64'h0, bit i set means this node publishes ID i.
- SUB_MASK, 64'h0, bit i set means this node subscribes to ID i (ID 0x3C is always subscribed).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-low reset
- bit_tick  in  1  one-cycle pulse per LIN bit time
- bus_dominant  in  1  synchronized RX level, 1 = dominant
- header_valid  in  1  pulse: a PID byte was received after break/sync
- pid  in  8  protected identifier, valid with header_valid
- rx_byte_valid  in  1  pulse: data/checksum byte received
- rx_byte  in  8  received byte
- tx_done  in  1  pulse: transmitter finished sending the response
- local_wake  in  1  application wake request (level)
- tx_start  out  1  pulse: start transmitting the response for resp_id
- resp_id  out  6  frame ID being handled
- resp_len  out  4  data bytes in the response (2, 4 or 8)
- rx_active  out  1  high while collecting a subscribed response
- frame_ok  out  1  pulse: frame completed correctly
- frame_err  out  1  pulse: parity, checksum, timeout or abort error
- sleep_mode  out  1  high in SLEEP
- wake_drive  out  1  high while driving the wakeup pulse
- init_finish  out  1  high once INIT has completed

Behaviour:
- Reset values:
  - State INIT; all counters 0.
  - All outputs 0 except resp_len = 2.
- States: INIT, IDLE, RX_DATA, RX_CHK, TX_RESP, SLEEP, WAKE.
- Tick counter:
  - Counts bit_tick.
  - Clears on every state change.
  - In IDLE it also clears on any bus_dominant = 1.
- INIT: after INIT_TICKS ticks, go to IDLE and set init_finish = 1 (it stays 1 until reset).
- IDLE, on header_valid:
  - ID = pid[5:0].
  - Expected parity: P0 = ID0^ID1^ID2^ID4, P1 = ~(ID1^ID3^ID4^ID5), compared against pid[7:6].
  - Parity mismatch: pulse frame_err next cycle, stay in IDLE.
  - resp_len = 2 for ID 0–31, 4 for ID 32–47, 8 for ID 48–63.
  - ID 0x3C forces resp_len = 8.
  - Publish (PUB_MASK[ID]): pulse tx_start one cycle later, go to TX_RESP.
  - Subscribe (SUB_MASK[ID] or ID == 0x3C): go to RX_DATA with rx_active = 1; checksum accumulator seeded.
  - Neither set: ignore, stay in IDLE.
  - PUB_MASK takes priority if both mask bits are set.
- IDLE, inactivity: if the counter reaches IDLE_TIMEOUT, go to SLEEP.
- Checksum:
  - 8-bit add with end-around carry, then inverted.
  - Seed = pid for the enhanced checksum (IDs 0x00–0x3B).
  - Seed = 0 for the classic checksum (0x3C, 0x3D).
- RX_DATA:
  - Each rx_byte_valid accumulates the byte and increments the byte index.
  - byte 0 of ID 0x3C is latched.
  - After resp_len bytes, go to RX_CHK.
- RX_CHK, on rx_byte_valid:
  - Match: pulse frame_ok.
  - Mismatch: pulse frame_err.
  - Either way go to IDLE and drop rx_active.
  - Go-to-sleep: if ID == 0x3C, the latched byte 0 == 0x00 and the checksum is OK, go to SLEEP instead of IDLE.
- TX_RESP: on tx_done, pulse frame_ok and go to IDLE.
- Timeout: in RX_DATA, RX_CHK or TX_RESP, the counter reaching RESP_TIMEOUT pulses frame_err and goes to IDLE.
- New header mid-response: header_valid in RX_DATA, RX_CHK or TX_RESP aborts the current frame.
  - frame_err pulses.
  - The new header is evaluated exactly as in IDLE in the same cycle.
- SLEEP:
  - sleep_mode = 1.
  - bus_dominant sampled high on a bit_tick: go to INIT (bus wakeup).
  - Else if local_wake = 1: go to WAKE.
  - Bus wakeup wins if both occur together.
- WAKE: wake_drive = 1 for WAKE_TICKS ticks, then go to INIT. init_finish is not cleared.
- Pulse outputs are exactly one cycle wide. All outputs are registered.
- Reset asserted mid-frame returns to INIT with no pulse emitted.

Decomposition:
- Shared package lin_pkg holds:
  - State encoding constants.
  - ID_MASTER_REQ = 6'h3C, ID_SLAVE_RESP = 6'h3D.
  - The length-by-ID function.
  - The PID parity function.
- Sub-module lin_checksum_acc:
  - Inputs: clear/seed, byte, enable.
  - Output: 8-bit inverted checksum.

Test Plan:
- Reset release, 30 bit_ticks -> init_finish = 1 on tick 30; state IDLE; outputs otherwise 0.
- PUB_MASK[0x10] = 1; header pid = 0x50 (ID 0x10, P1 = 0, P0 = 1) -> tx_start pulse, resp_len = 2; tx_done -> frame_ok pulse.
- SUB_MASK[0x22] = 1; pid = 0xE2; bytes 0x11,0x22,0x33,0x44 plus the correct enhanced checksum -> frame_ok. Repeat with checksum ^ 0x01 -> frame_err.
- Header pid = 0x3C, bytes 0x00, 0xFF ×7, classic checksum 0x00 -> frame_ok, then sleep_mode = 1 the next cycle.
- In SLEEP, assert local_wake -> wake_drive = 1 for 8 bit_ticks, then INIT, then IDLE after 30 ticks. Separately, bus_dominant on a tick -> INIT directly.
- Bad parity pid = 0x10 -> frame_err. Header then 2 bytes then silence -> frame_err after 140 ticks. 76800 recessive ticks in IDLE -> SLEEP.
